// File: rtl/pc_call_stack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : pc_pkg                                                       |
// | Purpose   : Shared types and constants for the program counter with      |
// |             integrated return-address stack.                             |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package pc_pkg;

   // Operation selected for the PC in a given cycle, after priority resolution.
   typedef enum logic [2:0] {
      PC_HOLD = 3'd0,
      PC_INC  = 3'd1,
      PC_JMP  = 3'd2,
      PC_CALL = 3'd3,
      PC_RET  = 3'd4
   } pc_op_e;

   // Address the PC returns to on reset.
   localparam int unsigned PC_RESET_ADDR = 0;

   // Priority decoder: stall beats jump, jump beats call, call beats return.
   // Lower-priority strobes in the same cycle are simply not selected, so
   // they cannot cause any stack or flag side effect downstream.
   function automatic pc_op_e pc_decode(input logic en,
                                        input logic jmp,
                                        input logic call,
                                        input logic ret);
      pc_op_e op;
      if (!en)       op = PC_HOLD;
      else if (jmp)  op = PC_JMP;
      else if (call) op = PC_CALL;
      else if (ret)  op = PC_RET;
      else           op = PC_INC;
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_call_stack_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : pc_call_stack_if                                             |
// | Purpose   : Control strobes from the control unit into the PC, and the   |
// |             fetch address / stack status back out.                       |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface pc_call_stack_if #(
   parameter int INSTR_ADDR_SIZE = 5,
   parameter int STACK_DEPTH     = 4
);
   localparam int LVL_W = $clog2(STACK_DEPTH + 1);

   // Control unit -> PC
   logic                       en;
   logic                       jmp;
   logic                       call;
   logic                       ret;
   logic [INSTR_ADDR_SIZE-1:0] jmp_addr;

   // PC -> fetch path / status
   logic [INSTR_ADDR_SIZE-1:0] instr_addr;
   logic [LVL_W-1:0]           stack_level;
   logic                       stack_full;
   logic                       stack_empty;
   logic                       stack_ovf;
   logic                       stack_unf;

   // Control-unit side.
   modport master (
      output en, jmp, call, ret, jmp_addr,
      input  instr_addr, stack_level, stack_full, stack_empty,
             stack_ovf, stack_unf
   );

   // Program-counter side.
   modport slave (
      input  en, jmp, call, ret, jmp_addr,
      output instr_addr, stack_level, stack_full, stack_empty,
             stack_ovf, stack_unf
   );
endinterface
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : pc_ret_stack                                                 |
// | Purpose   : LIFO of return addresses. Pushes while full and pops while   |
// |             empty are ignored, leaving contents and level untouched.     |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module pc_ret_stack #(
   parameter int INSTR_ADDR_SIZE = 5,
   parameter int STACK_DEPTH     = 4,
   parameter int LVL_W           = $clog2(STACK_DEPTH + 1)
) (
   input  wire logic                       clk,
   input  wire logic                       rst,
   input  wire logic                       push,
   input  wire logic                       pop,
   input  wire logic [INSTR_ADDR_SIZE-1:0] din,
   output logic      [INSTR_ADDR_SIZE-1:0] dout,
   output logic      [LVL_W-1:0]           level,
   output logic                            full,
   output logic                            empty
);
   // Index width for the entry array; depth is at least 2 so this is >= 1.
   localparam int IDX_W = $clog2(STACK_DEPTH);

   logic [INSTR_ADDR_SIZE-1:0] r_mem [STACK_DEPTH];
   logic [LVL_W-1:0]           r_level;

   logic             w_full;
   logic             w_empty;
   logic             w_do_push;
   logic             w_do_pop;
   logic [IDX_W-1:0] w_wr_idx;
   logic [IDX_W-1:0] w_top_idx;
   logic [LVL_W-1:0] w_level_m1;

   assign w_full     = (r_level == LVL_W'(STACK_DEPTH));
   assign w_empty    = (r_level == '0);
   // Push wins if both arrive together; the top-level decoder never asks for
   // both, but the stack stays well defined on its own.
   assign w_do_push  = push && !w_full;
   assign w_do_pop   = pop && !push && !w_empty;
   assign w_level_m1 = r_level - LVL_W'(1);
   // The next free slot is the current level; the top entry sits one below.
   assign w_wr_idx   = IDX_W'(r_level);
   assign w_top_idx  = IDX_W'(w_level_m1);

   // Level counter tracks the number of valid entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_level <= '0;
      end else if (w_do_push) begin
         r_level <= r_level + LVL_W'(1);
      end else if (w_do_pop) begin
         r_level <= w_level_m1;
      end
   end

   // Entry storage; contents are meaningless until pushed, so no reset.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[w_wr_idx] <= din;
      end
   end

   // Top-of-stack read; forced to zero when empty so no stale value leaks out.
   always_comb begin
      dout = '0;
      if (!w_empty) begin
         dout = r_mem[w_top_idx];
      end
   end

   assign level = r_level;
   assign full  = w_full;
   assign empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/pc_call_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : pc_call_stack                                                |
// | Purpose   : Program counter with hardware return-address stack,          |
// |             stall control and sticky overflow/underflow flags.           |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module pc_call_stack
   import pc_pkg::*;
#(
   parameter int INSTR_ADDR_SIZE = 5,
   parameter int STACK_DEPTH     = 4
) (
   input  wire logic        clk,
   input  wire logic        rst,
   pc_call_stack_if.slave   bus
);
   localparam int LVL_W = $clog2(STACK_DEPTH + 1);

   logic [INSTR_ADDR_SIZE-1:0] r_pc;
   logic                       r_ovf;
   logic                       r_unf;

   pc_op_e                     w_op;
   logic [INSTR_ADDR_SIZE-1:0] w_pc_inc;
   logic [INSTR_ADDR_SIZE-1:0] w_stk_dout;
   logic [LVL_W-1:0]           w_stk_level;
   logic                       w_stk_full;
   logic                       w_stk_empty;
   logic                       w_push;
   logic                       w_pop;

   assign w_op     = pc_decode(bus.en, bus.jmp, bus.call, bus.ret);
   // Natural modulo-2^W wrap: all-ones rolls over to zero.
   assign w_pc_inc = r_pc + INSTR_ADDR_SIZE'(1);

   // Stack traffic only for a selected call/ret that the stack can honour;
   // reset takes precedence so nothing is pushed in a reset cycle.
   assign w_push = !rst && (w_op == PC_CALL) && !w_stk_full;
   assign w_pop  = !rst && (w_op == PC_RET)  && !w_stk_empty;

   pc_ret_stack #(
      .INSTR_ADDR_SIZE (INSTR_ADDR_SIZE),
      .STACK_DEPTH     (STACK_DEPTH),
      .LVL_W           (LVL_W)
   ) u_ret_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_pc_inc),
      .dout  (w_stk_dout),
      .level (w_stk_level),
      .full  (w_stk_full),
      .empty (w_stk_empty)
   );

   // PC update and sticky error flags, following the decoded operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc  <= INSTR_ADDR_SIZE'(PC_RESET_ADDR);
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         case (w_op)
            PC_HOLD: r_pc <= r_pc;
            PC_INC:  r_pc <= w_pc_inc;
            PC_JMP:  r_pc <= bus.jmp_addr;
            PC_CALL: begin
               // The jump is taken even when the return address is lost.
               r_pc <= bus.jmp_addr;
               if (w_stk_full) begin
                  r_ovf <= 1'b1;
               end
            end
            PC_RET: begin
               // A return with nothing to return to behaves like a plain step.
               if (w_stk_empty) begin
                  r_pc  <= w_pc_inc;
                  r_unf <= 1'b1;
               end else begin
                  r_pc <= w_stk_dout;
               end
            end
            default: r_pc <= r_pc;
         endcase
      end
   end

   assign bus.instr_addr  = r_pc;
   assign bus.stack_level = w_stk_level;
   assign bus.stack_full  = w_stk_full;
   assign bus.stack_empty = w_stk_empty;
   assign bus.stack_ovf   = r_ovf;
   assign bus.stack_unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_call_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_pc_call_stack                                             |
// | Purpose   : Directed self-checking bench for pc_call_stack (W=5, D=4).   |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_pc_call_stack;

   localparam int W = 5;
   localparam int D = 4;

   typedef struct {
      string      tag;
      logic [4:0] pc;
      logic [2:0] lvl;
      logic       ovf;
      logic       unf;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb_q[$];
   int   n_total;
   int   n_pass;

   pc_call_stack_if #(.INSTR_ADDR_SIZE(W), .STACK_DEPTH(D)) bus ();

   pc_call_stack #(.INSTR_ADDR_SIZE(W), .STACK_DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one scoreboard entry against the outputs after the edge.
   task automatic check_out();
      exp_t x;
      logic exp_full;
      logic exp_empty;
      x = sb_q.pop_front();
      exp_full  = (x.lvl == 3'(D));
      exp_empty = (x.lvl == 3'd0);
      n_total++;
      assert (bus.instr_addr === x.pc) n_pass++;
      else $error("FAIL %s instr_addr: got %0d want %0d", x.tag, bus.instr_addr, x.pc);
      n_total++;
      assert (bus.stack_level === x.lvl) n_pass++;
      else $error("FAIL %s stack_level: got %0d want %0d", x.tag, bus.stack_level, x.lvl);
      n_total++;
      assert (bus.stack_full === exp_full) n_pass++;
      else $error("FAIL %s stack_full: got %b want %b", x.tag, bus.stack_full, exp_full);
      n_total++;
      assert (bus.stack_empty === exp_empty) n_pass++;
      else $error("FAIL %s stack_empty: got %b want %b", x.tag, bus.stack_empty, exp_empty);
      n_total++;
      assert (bus.stack_ovf === x.ovf) n_pass++;
      else $error("FAIL %s stack_ovf: got %b want %b", x.tag, bus.stack_ovf, x.ovf);
      n_total++;
      assert (bus.stack_unf === x.unf) n_pass++;
      else $error("FAIL %s stack_unf: got %b want %b", x.tag, bus.stack_unf, x.unf);
   endtask

   // Drive one cycle of stimulus, queue its expected result, check after edge.
   task automatic step(input string tag, input bit r, input bit e, input bit j,
                       input bit c, input bit rt, input int a,
                       input int epc, input int elvl, input bit eovf, input bit eunf);
      exp_t x;
      rst          = r;
      bus.en       = e;
      bus.jmp      = j;
      bus.call     = c;
      bus.ret      = rt;
      bus.jmp_addr = 5'(a);
      x.tag = tag;
      x.pc  = 5'(epc);
      x.lvl = 3'(elvl);
      x.ovf = eovf;
      x.unf = eunf;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      n_total      = 0;
      n_pass       = 0;
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.jmp      = 1'b0;
      bus.call     = 1'b0;
      bus.ret      = 1'b0;
      bus.jmp_addr = '0;

      // Reset state.
      step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Free-running increment with wrap past 31.
      for (int k = 1; k <= 39; k++)
         step("idle", 0, 1, 0, 0, 0, 0, k % 32, 0, 0, 0);

      // Single call/return.
      step("rst_a", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 3; k++)
         step("inc_a", 0, 1, 0, 0, 0, 0, k, 0, 0, 0);
      step("call20", 0, 1, 0, 1, 0, 20, 20, 1, 0, 0);
      step("inc21",  0, 1, 0, 0, 0, 0,  21, 1, 0, 0);
      step("inc22",  0, 1, 0, 0, 0, 0,  22, 1, 0, 0);
      step("ret4",   0, 1, 0, 0, 1, 0,  4,  0, 0, 0);

      // Nested calls to full, overflow, then unwind.
      step("rst_b",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("inc_b",  0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      step("call10", 0, 1, 0, 1, 0, 10, 10, 1, 0, 0);
      step("call15", 0, 1, 0, 1, 0, 15, 15, 2, 0, 0);
      step("call22", 0, 1, 0, 1, 0, 22, 22, 3, 0, 0);
      step("call27", 0, 1, 0, 1, 0, 27, 27, 4, 0, 0);
      step("call30", 0, 1, 0, 1, 0, 30, 30, 4, 1, 0);
      step("ret23",  0, 1, 0, 0, 1, 0,  23, 3, 1, 0);
      step("ret16",  0, 1, 0, 0, 1, 0,  16, 2, 1, 0);
      step("ret11",  0, 1, 0, 0, 1, 0,  11, 1, 1, 0);
      step("ret2",   0, 1, 0, 0, 1, 0,  2,  0, 1, 0);

      // Underflow: return while empty acts as increment, flag is sticky.
      step("rst_c",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 6; k++)
         step("inc_c", 0, 1, 0, 0, 0, 0, k, 0, 0, 0);
      step("ret_unf", 0, 1, 0, 0, 1, 0, 7, 0, 0, 1);
      for (int k = 8; k <= 17; k++)
         step("unf_hold", 0, 1, 0, 0, 0, 0, k, 0, 0, 1);
      step("unf_stall", 0, 0, 0, 0, 0, 0, 17, 0, 0, 1);
      step("unf_clr",   1, 0, 0, 0, 0, 0, 0,  0, 0, 0);

      // All strobes at once: jump wins, stack untouched.
      step("call5",   0, 1, 0, 1, 0, 5, 5, 1, 0, 0);
      step("jmp_all", 0, 1, 1, 1, 1, 9, 9, 1, 0, 0);
      step("ret1",    0, 1, 0, 0, 1, 0, 1, 0, 0, 0);

      // Stall while call is held, then reset with a level-3 stack.
      step("call12", 0, 1, 0, 1, 0, 12, 12, 1, 0, 0);
      for (int k = 0; k < 5; k++)
         step("stall", 0, 0, 0, 1, 0, 25, 12, 1, 0, 0);
      step("call20b", 0, 1, 0, 1, 0, 20, 20, 2, 0, 0);
      step("call24",  0, 1, 0, 1, 0, 24, 24, 3, 0, 0);
      step("rst_mid", 1, 1, 0, 1, 0, 7,  0,  0, 0, 0);
      step("ret_post", 0, 1, 0, 0, 1, 0, 1,  0, 0, 1);
      step("rst_d",   1, 0, 0, 0, 0, 0,  0,  0, 0, 0);

      // Back-to-back call then return.
      step("call17", 0, 1, 0, 1, 0, 17, 17, 1, 0, 0);
      step("ret_b2b", 0, 1, 0, 0, 1, 0, 1, 0, 0, 0);

      // Call from the top address: return address wraps to 0.
      step("jmp31",  0, 1, 1, 0, 0, 31, 31, 0, 0, 0);
      step("call4",  0, 1, 0, 1, 0, 4,  4,  1, 0, 0);
      step("ret0",   0, 1, 0, 0, 1, 0,  0,  0, 0, 0);

      n_total++;
      assert (sb_q.size() === 0) n_pass++;
      else $error("FAIL sb_drain: got %0d want 0", sb_q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised program counter with an integrated hardware return-address stack, enable/stall control and sticky stack-error flags. It replaces the single-return-address counter in the instruction-fetch path. Call and return addresses are managed internally, so the control unit issues only `call`/`ret` strobes plus a target address. The instruction memory and ALU sequencing consume `instr_addr` directly.

## Interface
Parameters:
- `INSTR_ADDR_SIZE`, default 5: width of instruction addresses.
- `STACK_DEPTH`, default 4: number of return-address entries; must be ≥ 2.

Ports:
- `clk` input, 1: single system clock, rising-edge.
- `rst` input, 1: reset, synchronous, active-high.
- `en` input, 1: advance enable; 0 freezes all state (stall).
- `jmp` input, 1: load `jmp_addr` into PC.
- `call` input, 1: push return address, load `jmp_addr` into PC.
- `ret` input, 1: pop top of stack into PC.
- `jmp_addr` input, `INSTR_ADDR_SIZE`: target for `jmp` and `call`.
- `instr_addr` output, `INSTR_ADDR_SIZE`: current instruction address (registered).
- `stack_level` output, `$clog2(STACK_DEPTH+1)`: number of valid entries.
- `stack_full` output, 1: `stack_level == STACK_DEPTH`.
- `stack_empty` output, 1: `stack_level == 0`.
- `stack_ovf` output, 1: sticky; a `call` was issued while full.
- `stack_unf` output, 1: sticky; a `ret` was issued while empty.

## Operation
- Priority per cycle: `rst` > `!en` > `jmp` > `call` > `ret` > increment. Lower-priority strobes asserted in the same cycle are ignored, with no stack or flag side effects.
- `rst`: PC=0, `stack_level`=0, `stack_ovf`=`stack_unf`=0. Entry contents need no reset.
- `en`=0: PC, stack and flags hold. Stall does not clear flags.
- Increment: PC ← PC+1 modulo 2^`INSTR_ADDR_SIZE`; all-ones wraps to 0.
- `jmp`: PC ← `jmp_addr`. Stack unchanged.
- `call`, not full: entry[`stack_level`] ← PC+1 (mod 2^W), level+1, PC ← `jmp_addr`.
- `call`, full: PC ← `jmp_addr` (jump still taken). Push is dropped and existing entries are untouched. `stack_ovf` ← 1.
- `ret`, not empty: PC ← entry[level-1], level-1.
- `ret`, empty: treated as increment (PC ← PC+1). `stack_unf` ← 1.
- Error flags clear only on `rst`.
- `stack_full` and `stack_empty` are combinational decodes of registered `stack_level`.

## Timing
- All state updates occur on the rising `clk` edge. Inputs are sampled at that edge.
- Latency is 1 cycle: a strobe in cycle N drives the new `instr_addr` in cycle N+1.
- Stack effects are visible 1 cycle after the strobe: `stack_level` and flags update on the same edge as PC.
- Back-to-back `call`,`ret` on consecutive enabled cycles returns to the original PC+1 with no bubble.
- `rst` asserted mid-call sequence discards all pending stack contents. The next cycle shows PC=0 with level 0.
- All outputs after reset: `instr_addr`=0, `stack_level`=0, `stack_empty`=1, `stack_full`=0, `stack_ovf`=0, `stack_unf`=0.

## Structure
- Shared package `pc_pkg`:
  - `pc_op_e` enum (`PC_HOLD`, `PC_INC`, `PC_JMP`, `PC_CALL`, `PC_RET`) produced by the priority decoder.
  - Reset-address constant `PC_RESET_ADDR` = 0.
- Sub-module `pc_ret_stack`:
  - Parametrised LIFO of `STACK_DEPTH` × `INSTR_ADDR_SIZE`.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout` (top entry), `level`, `full`, `empty`.
  - Internally ignores a push when full and a pop when empty.
- Top level holds the PC register, the op decoder and the sticky flags.

## Test plan
- Reset then 40 enabled idle cycles (W=5) → PC runs 0…31, wraps to 0 at cycle 32 and reaches 7 at cycle 39; flags stay 0.
- PC=3, `call` with `jmp_addr`=20 → PC=20, level=1. After 2 increments, `ret` → PC=4, level=0.
- Nested calls: 4 calls from PC 1, 10, 15, 22 (targets 10, 15, 22, 27) → `stack_full`=1. A 5th call to 30 → PC=30, `stack_ovf`=1, level=4. Four returns → PC 23, 16, 11, 2.
- `ret` with stack empty at PC=6 → PC=7, `stack_unf`=1. Flag persists through 10 cycles and clears only on `rst`.
- `jmp`=1, `call`=1, `ret`=1 simultaneously with `jmp_addr`=9 and level 1 → PC=9, level stays 1, no flags set.
- `en`=0 for 5 cycles while `call` is held at PC=12 → PC stays 12 and level unchanged. `rst` during a level-3 stack → PC=0, level=0.
